// File: rtl/roulette_pkg.sv
// Shared constants and encodings for the roulette wheel controller.
// Holds the slot count, the "00" code, colour encodings and spin states.
package roulette_pkg;

  localparam int WHEEL_SLOTS      = 38;
  localparam int DOUBLE_ZERO_CODE = 37;

  typedef enum logic [1:0] {
    GREEN = 2'd0,
    RED   = 2'd1,
    BLACK = 2'd2
  } color_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPIN  = 2'd1,
    DECEL = 2'd2,
    DONE  = 2'd3
  } spin_state_t;

endpackage

// File: rtl/roulette_position_to_number.sv
// Combinational wheel table: slot index (American order) to printed number,
// colour and zero flags. Ports: position in; number/is_zero/is_double_zero/color out.
module roulette_position_to_number
  import roulette_pkg::*;
(
  input  logic [5:0] position,
  output logic [5:0] number,
  output logic       is_zero,
  output logic       is_double_zero,
  output logic [1:0] color
);

  always_comb begin
    number = 6'd0;
    unique case (position)
      6'd0:  number = 6'd0;
      6'd1:  number = 6'd28;
      6'd2:  number = 6'd9;
      6'd3:  number = 6'd26;
      6'd4:  number = 6'd30;
      6'd5:  number = 6'd11;
      6'd6:  number = 6'd7;
      6'd7:  number = 6'd20;
      6'd8:  number = 6'd32;
      6'd9:  number = 6'd17;
      6'd10: number = 6'd5;
      6'd11: number = 6'd22;
      6'd12: number = 6'd34;
      6'd13: number = 6'd15;
      6'd14: number = 6'd3;
      6'd15: number = 6'd24;
      6'd16: number = 6'd36;
      6'd17: number = 6'd13;
      6'd18: number = 6'd1;
      6'd19: number = 6'd37;
      6'd20: number = 6'd27;
      6'd21: number = 6'd10;
      6'd22: number = 6'd25;
      6'd23: number = 6'd29;
      6'd24: number = 6'd12;
      6'd25: number = 6'd8;
      6'd26: number = 6'd19;
      6'd27: number = 6'd31;
      6'd28: number = 6'd18;
      6'd29: number = 6'd6;
      6'd30: number = 6'd21;
      6'd31: number = 6'd33;
      6'd32: number = 6'd16;
      6'd33: number = 6'd4;
      6'd34: number = 6'd23;
      6'd35: number = 6'd35;
      6'd36: number = 6'd14;
      6'd37: number = 6'd2;
      default: number = 6'd0;
    endcase
  end

  always_comb begin
    color = BLACK;
    unique case (number)
      6'd0, 6'd37: color = GREEN;
      6'd1, 6'd3, 6'd5, 6'd7, 6'd9,
      6'd12, 6'd14, 6'd16, 6'd18,
      6'd19, 6'd21, 6'd23, 6'd25,
      6'd27, 6'd30, 6'd32, 6'd34,
      6'd36: color = RED;
      default: color = BLACK;
    endcase
  end

  assign is_zero        = (number == 6'd0);
  assign is_double_zero = (number == 6'(DOUBLE_ZERO_CODE));

endmodule

// File: rtl/roulette_spin_controller.sv
// Roulette wheel pointer: spins at full speed, decelerates, stops at an LFSR-chosen slot.
// Ports: clk, reset, spin_start in; position, number, flags, color, busy, result_valid out.
module roulette_spin_controller
  import roulette_pkg::*;
#(
  parameter int          MIN_DELAY  = 4,
  parameter int          DELAY_INC  = 4,
  parameter int          MAX_DELAY  = 16,
  parameter int          BASE_STEPS = 76,
  parameter int          RAND_BITS  = 6,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spin_start,
  output logic [5:0] position,
  output logic [5:0] number,
  output logic       is_zero,
  output logic       is_double_zero,
  output logic [1:0] color,
  output logic       busy,
  output logic       result_valid
);

  localparam int DW = $clog2(MAX_DELAY + DELAY_INC + 1);
  localparam int SW = $clog2(BASE_STEPS + (1 << RAND_BITS));

  spin_state_t   state;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_next;
  logic [DW-1:0] tick;
  logic [DW-1:0] delay;
  logic [DW-1:0] delay_next;
  logic [SW-1:0] steps_left;
  logic [SW-1:0] rand_add;
  logic [5:0]    pos_next;
  logic          step_now;

  // Right-shifting Galois form; taps B400 give a maximal-length sequence.
  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

  generate
    if (RAND_BITS > 0) begin : g_rand
      assign rand_add = SW'(lfsr[RAND_BITS-1:0]);
    end else begin : g_norand
      assign rand_add = '0;
    end
  endgenerate

  assign pos_next   = (position == 6'(WHEEL_SLOTS - 1)) ? 6'd0 : position + 6'd1;
  assign step_now   = (tick == delay - DW'(1));
  assign delay_next = delay + DW'(DELAY_INC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      position     <= 6'd0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      lfsr         <= SEED;
      tick         <= '0;
      delay        <= '0;
      steps_left   <= '0;
    end else begin
      lfsr         <= lfsr_next;
      result_valid <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (spin_start) begin
            state      <= SPIN;
            busy       <= 1'b1;
            steps_left <= SW'(BASE_STEPS) + rand_add;
            delay      <= DW'(MIN_DELAY);
            tick       <= '0;
          end
        end
        SPIN: begin
          if (step_now) begin
            position   <= pos_next;
            tick       <= '0;
            steps_left <= steps_left - SW'(1);
            if (steps_left == SW'(1)) begin
              state <= DECEL;
              delay <= DW'(MIN_DELAY + DELAY_INC);
            end
          end else begin
            tick <= tick + DW'(1);
          end
        end
        DECEL: begin
          if (step_now) begin
            position <= pos_next;
            tick     <= '0;
            // Stop on the step whose following delay would exceed the limit.
            if (delay_next > DW'(MAX_DELAY)) begin
              state        <= DONE;
              busy         <= 1'b0;
              result_valid <= 1'b1;
            end else begin
              delay <= delay_next;
            end
          end else begin
            tick <= tick + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  roulette_position_to_number u_map (
    .position       (position),
    .number         (number),
    .is_zero        (is_zero),
    .is_double_zero (is_double_zero),
    .color          (color)
  );

endmodule

// File: tb/tb_roulette_spin_controller.sv
// Directed bench for roulette_spin_controller: reset, timing, map, wrap,
// ignored requests, mid-spin reset and a randomised back-to-back run.
module tb_roulette_spin_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ss_a = 1'b0, ss_b = 1'b0, ss_c = 1'b0, ss_d = 1'b0;

  logic [5:0] pos_a, num_a, pos_b, num_b, pos_c, num_c, pos_d, num_d;
  logic [1:0] col_a, col_b, col_c, col_d;
  logic z_a, dz_a, busy_a, rv_a;
  logic z_b, dz_b, busy_b, rv_b;
  logic z_c, dz_c, busy_c, rv_c;
  logic z_d, dz_d, busy_d, rv_d;

  int passed = 0;
  int total  = 0;

  int tbl [38] = '{0, 28, 9, 26, 30, 11, 7, 20, 32, 17,
                   5, 22, 34, 15, 3, 24, 36, 13, 1, 37,
                   27, 10, 25, 29, 12, 8, 19, 31, 18, 6,
                   21, 33, 16, 4, 23, 35, 14, 2};

  always #5 clk = ~clk;

  roulette_spin_controller #(.BASE_STEPS(40), .RAND_BITS(0)) u_a (
    .clk(clk), .reset(reset), .spin_start(ss_a),
    .position(pos_a), .number(num_a), .is_zero(z_a),
    .is_double_zero(dz_a), .color(col_a),
    .busy(busy_a), .result_valid(rv_a));

  roulette_spin_controller #(.BASE_STEPS(16), .RAND_BITS(0)) u_b (
    .clk(clk), .reset(reset), .spin_start(ss_b),
    .position(pos_b), .number(num_b), .is_zero(z_b),
    .is_double_zero(dz_b), .color(col_b),
    .busy(busy_b), .result_valid(rv_b));

  roulette_spin_controller #(.BASE_STEPS(76), .RAND_BITS(0)) u_c (
    .clk(clk), .reset(reset), .spin_start(ss_c),
    .position(pos_c), .number(num_c), .is_zero(z_c),
    .is_double_zero(dz_c), .color(col_c),
    .busy(busy_c), .result_valid(rv_c));

  // Default randomisation, full-speed delay shortened to keep 200 spins brief.
  roulette_spin_controller #(.MIN_DELAY(1)) u_d (
    .clk(clk), .reset(reset), .spin_start(ss_d),
    .position(pos_d), .number(num_d), .is_zero(z_d),
    .is_double_zero(dz_d), .color(col_d),
    .busy(busy_d), .result_valid(rv_d));

  function automatic int color_of(input int n);
    if (n == 0 || n == 37) return 0;
    case (n)
      1, 3, 5, 7, 9, 12, 14, 16, 18, 19, 21,
      23, 25, 27, 30, 32, 34, 36: return 1;
      default: return 2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    int t_a, t_b, t_c, cnt_a, cnt_b, cnt_c, steps_c, prev_c, exp_c;
    int got, distinct;
    bit wrap_c;
    bit seen [38];

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    chk("rst_pos", pos_a, 0);
    chk("rst_num", num_a, 0);
    chk("rst_zero", z_a, 1);
    chk("rst_dzero", dz_a, 0);
    chk("rst_color", col_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_rv", rv_a, 0);
    reset = 1'b0;
    @(negedge clk);

    // Three deterministic spins launched together
    ss_a = 1'b1; ss_b = 1'b1; ss_c = 1'b1;
    @(negedge clk);
    ss_a = 1'b0; ss_b = 1'b0; ss_c = 1'b0;
    t_a = 0; t_b = 0; t_c = 0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    steps_c = 0; prev_c = 0; wrap_c = 0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) chk("a_busy_up", busy_a, 1);
      if (n == 3) chk("a_pre_step", pos_a, 0);
      if (n == 4) chk("a_first_step", pos_a, 1);
      if (rv_a) begin
        cnt_a++; t_a = n;
        chk("a_busy_fall", busy_a, 0);
      end
      if (rv_b) begin cnt_b++; t_b = n; end
      if (rv_c) begin cnt_c++; t_c = n; end
      if (int'(pos_c) != prev_c) begin
        exp_c = (prev_c == 37) ? 0 : prev_c + 1;
        chk("c_step", pos_c, exp_c);
        chk("c_map_num", num_c, tbl[exp_c]);
        chk("c_map_col", col_c, color_of(tbl[exp_c]));
        if (prev_c == 37) wrap_c = 1;
        prev_c = int'(pos_c);
        steps_c++;
      end
    end
    chk("a_rv_time", t_a, 196);
    chk("a_rv_count", cnt_a, 1);
    chk("a_pos", pos_a, 5);
    chk("a_num", num_a, 11);
    chk("a_color", col_a, 2);
    chk("b_rv_time", t_b, 100);
    chk("b_rv_count", cnt_b, 1);
    chk("b_pos", pos_b, 19);
    chk("b_num", num_b, 37);
    chk("b_dzero", dz_b, 1);
    chk("b_zero", z_b, 0);
    chk("b_color", col_b, 0);
    chk("c_rv_time", t_c, 340);
    chk("c_rv_count", cnt_c, 1);
    chk("c_pos", pos_c, 3);
    chk("c_num", num_c, 26);
    chk("c_color", col_c, 2);
    chk("c_steps", steps_c, 79);
    chk("c_wrap", wrap_c, 1);

    // Restart A from DONE; extra requests in SPIN and DECEL are ignored
    ss_a = 1'b1;
    @(negedge clk);
    ss_a = 1'b0;
    t_a = 0; cnt_a = 0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      ss_a = (n == 50 || n == 170);
      if (rv_a) begin cnt_a++; t_a = n; end
    end
    ss_a = 1'b0;
    chk("a2_rv_time", t_a, 196);
    chk("a2_rv_count", cnt_a, 1);
    chk("a2_pos", pos_a, 10);
    chk("a2_num", num_a, 5);
    chk("a2_color", col_a, 1);

    // Reset in the middle of a spin
    ss_a = 1'b1;
    @(negedge clk);
    ss_a = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_busy_pre", busy_a, 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_pos", pos_a, 0);
    chk("mid_num", num_a, 0);
    chk("mid_zero", z_a, 1);
    chk("mid_color", col_a, 0);
    chk("mid_busy", busy_a, 0);
    chk("mid_rv", rv_a, 0);
    reset = 1'b0;
    cnt_a = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (rv_a || busy_a) cnt_a++;
    end
    chk("mid_quiet", cnt_a, 0);

    // 200 back-to-back randomised spins
    for (int i = 0; i < 38; i++) seen[i] = 0;
    for (int i = 0; i < 200; i++) begin
      ss_d = 1'b1;
      @(negedge clk);
      ss_d = 1'b0;
      got = 0;
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk);
        if (rv_d) begin got = 1; break; end
      end
      chk("d_done", got, 1);
      chk("d_pos_range", pos_d <= 6'd37, 1);
      chk("d_lfsr_nz", u_d.lfsr != 16'd0, 1);
      chk("d_map_num", num_d, tbl[pos_d % 38]);
      if (pos_d <= 6'd37) seen[pos_d] = 1;
    end
    distinct = 0;
    for (int i = 0; i < 38; i++) if (seen[i]) distinct++;
    chk("d_distinct_ge20", distinct >= 20, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
